// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I types plus the instruction-cache state and line types
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef enum logic {CHECK, FILL} icache_state_t;
  typedef logic [255:0] icache_line_t;
endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage with synchronous write and asynchronous read
module icache_array
  import rv32i_types::*;
#(
  parameter int NUM_SETS = 8,
  localparam int S = $clog2(NUM_SETS),
  localparam int T = 27 - S
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_we,
  input  logic [S-1:0] i_windex,
  input  logic [T-1:0] i_wtag,
  input  icache_line_t i_wline,
  input  logic [S-1:0] i_rindex,
  output logic         o_valid,
  output logic [T-1:0] o_tag,
  output icache_line_t o_line
);
  logic [NUM_SETS-1:0] r_valid;
  logic [T-1:0]        r_tag  [NUM_SETS];
  icache_line_t        r_data [NUM_SETS];
  // valid bits: reset invalidates every line, a fill validates its set
  always_ff @(posedge clk)
    if (reset) r_valid <= '0;
    else if (i_we) r_valid[i_windex] <= 1'b1;
  // tag and line payload need no reset because valid guards them
  always_ff @(posedge clk)
    if (i_we) begin
      r_tag[i_windex]  <= i_wtag;
      r_data[i_windex] <= i_wline;
    end
  assign o_valid = r_valid[i_rindex];
  assign o_tag   = r_tag[i_rindex];
  assign o_line  = r_data[i_rindex];
endmodule

// File: rtl/icache_responder.sv
// icache_responder: read-only direct-mapped icache, same-cycle hits, single-burst line fills
module icache_responder
  import rv32i_types::*;
#(
  parameter int NUM_SETS = 8,
  localparam int S = $clog2(NUM_SETS),
  localparam int T = 27 - S
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic [31:0]  mem_address,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  icache_state_t r_state;
  logic [26:0]   r_fill_addr;
  logic          w_valid;
  logic [T-1:0]  w_tag;
  icache_line_t  w_line;
  logic          w_hit;
  logic          w_miss;
  logic          w_we;
  logic          w_unused;
  assign w_unused = ^mem_address[1:0];
  assign w_hit    = w_valid && (w_tag == mem_address[31:S+5]);
  assign w_miss   = (r_state == CHECK) && mem_read && !w_hit;
  assign w_we     = !reset && (r_state == FILL) && pmem_resp;
  icache_array #(.NUM_SETS(NUM_SETS)) u_array (
    .clk      (clk),
    .reset    (reset),
    .i_we     (w_we),
    .i_windex (r_fill_addr[S-1:0]),
    .i_wtag   (r_fill_addr[26:S]),
    .i_wline  (pmem_rdata),
    .i_rindex (mem_address[S+4:5]),
    .o_valid  (w_valid),
    .o_tag    (w_tag),
    .o_line   (w_line)
  );
  // CHECK waits for a miss and latches its line address; FILL holds until pmem answers
  always_ff @(posedge clk)
    if (reset) begin
      r_state     <= CHECK;
      r_fill_addr <= '0;
    end else begin
      r_state <= (r_state == CHECK) ? (w_miss ? FILL : CHECK) : (pmem_resp ? CHECK : FILL);
      if (w_miss) r_fill_addr <= mem_address[31:5];
    end
  // outputs are gated by reset so nothing leaks out during the reset cycle
  always_comb begin
    mem_resp     = !reset && (r_state == CHECK) && mem_read && w_hit;
    mem_rdata    = mem_resp ? w_line[{mem_address[4:2], 5'b0} +: 32] : 32'h0;
    pmem_read    = !reset && (r_state == FILL);
    pmem_address = pmem_read ? {r_fill_addr, 5'b0} : 32'h0;
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed-vector checks of hit, miss, eviction, mid-fill change and reset
module tb_icache_responder;
  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  int vectors = 0;
  int miscompares = 0;

  icache_responder #(.NUM_SETS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] make_line(input logic [31:0] b);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = b + 32'(k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_hit(input logic [31:0] addr, input logic [31:0] word, input string name);
    mem_read = 1'b1;
    mem_address = addr;
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b1 || mem_rdata !== word || pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: resp=%b rdata=%h pmem_read=%b, required resp=1 rdata=%h pmem_read=0", name, mem_resp, mem_rdata, pmem_read, word);
    end
    tick();
  endtask

  task automatic run_fill(input logic [31:0] addr, input logic [31:0] pm_addr, input logic [31:0] base, input int waits, input logic [31:0] mid_addr, input string name);
    mem_read = 1'b1;
    mem_address = addr;
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_miss: resp=%b pmem_read=%b, required 0 0", name, mem_resp, pmem_read);
    end
    tick();
    mem_address = mid_addr;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      vectors++;
      if (pmem_read !== 1'b1 || pmem_address !== pm_addr || mem_resp !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_wait%0d: pmem_read=%b pmem_address=%h resp=%b, required 1 %h 0", name, i, pmem_read, pmem_address, mem_resp, pm_addr);
      end
      tick();
    end
    pmem_resp = 1'b1;
    pmem_rdata = make_line(base);
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b1 || pmem_address !== pm_addr || mem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_resp_cycle: pmem_read=%b pmem_address=%h resp=%b, required 1 %h 0", name, pmem_read, pmem_address, mem_resp, pm_addr);
    end
    tick();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_read = 1'b1;
    mem_address = 32'h44;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    tick();
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b0 || mem_rdata !== 32'h0 || pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: resp=%b rdata=%h pmem_read=%b, required 0 0 0", mem_resp, mem_rdata, pmem_read);
    end
    tick();
    reset = 1'b0;
    mem_read = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
        miscompares++;
        $display("FAIL idle%0d: resp=%b pmem_read=%b pmem_address=%h, required 0 0 0", i, mem_resp, pmem_read, pmem_address);
      end
      tick();
    end
  endtask

  task automatic test_cold_miss();
    run_fill(32'h44, 32'h40, 32'hA000_0000, 3, 32'h44, "cold");
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b1 || mem_rdata !== 32'hA000_0001 || pmem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL cold_resp: resp=%b rdata=%h pmem_read=%b, required 1 a0000001 0", mem_resp, mem_rdata, pmem_read);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    expect_hit(32'h5C, 32'hA000_0007, "hit_5c");
    expect_hit(32'h47, 32'hA000_0001, "hit_low_bits");
    expect_hit(32'h50, 32'hA000_0004, "hit_50");
  endtask

  task automatic test_conflict();
    run_fill(32'h140, 32'h140, 32'hB000_0000, 2, 32'h140, "evict");
    expect_hit(32'h140, 32'hB000_0000, "evict_hit");
    run_fill(32'h40, 32'h40, 32'hA000_0000, 1, 32'h40, "refill");
    expect_hit(32'h40, 32'hA000_0000, "refill_hit");
  endtask

  task automatic test_addr_change();
    run_fill(32'h80, 32'h80, 32'hC000_0000, 2, 32'h100, "chg");
    run_fill(32'h100, 32'h100, 32'hD000_0000, 0, 32'h100, "chg_second");
    expect_hit(32'h104, 32'hD000_0001, "chg_second_hit");
    expect_hit(32'h80, 32'hC000_0000, "chg_first_hit");
  endtask

  task automatic test_reset_mid_fill();
    mem_read = 1'b1;
    mem_address = 32'h1E0;
    tick();
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h1E0) begin
      miscompares++;
      $display("FAIL rst_fill_start: pmem_read=%b pmem_address=%h, required 1 000001e0", pmem_read, pmem_address);
    end
    tick();
    reset = 1'b1;
    pmem_resp = 1'b1;
    pmem_rdata = make_line(32'hE000_0000);
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_cycle_resp: resp=%b, required 0", mem_resp);
    end
    tick();
    reset = 1'b0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after: pmem_read=%b resp=%b, required 0 0", pmem_read, mem_resp);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h1E0) begin
      miscompares++;
      $display("FAIL rst_remiss: pmem_read=%b pmem_address=%h, required 1 000001e0", pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    pmem_rdata = make_line(32'hF000_0000);
    tick();
    pmem_resp = 1'b0;
    expect_hit(32'h1E8, 32'hF000_0002, "rst_refill_hit");
    mem_address = 32'h80;
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_cleared_line: resp=%b, required 0", mem_resp);
    end
    mem_read = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_addr_change();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/icache_responder.md
# icache_responder

Read-only, direct-mapped instruction cache that answers the fetch stage's instruction-port requests. It sits between the fetch stage and the physical-memory arbiter. Hits are returned combinationally in the request cycle. Misses fill one 256-bit line from physical memory with a single burst read, then respond.

## Interface
Parameters:
- NUM_SETS, 8, number of lines; power of two, ≥2. Index width S = log2(NUM_SETS); tag width = 27 − S.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_read  in  1  fetch request; held high with stable mem_address until mem_resp
- mem_address  in  32  byte address; bits [1:0] ignored
- mem_rdata  out  32  instruction word; valid only when mem_resp=1, else 0
- mem_resp  out  1  one-cycle response strobe
- pmem_read  out  1  line-fill request to physical memory
- pmem_address  out  32  line-aligned fill address (bits [4:0]=0)
- pmem_rdata  in  256  fill line; word k at bits [32k+31:32k]
- pmem_resp  in  1  fill data valid, single cycle

## Operation
- Address split: offset [4:0], word select [4:2], index [S+4:5], tag [31:S+5].
- Per set: valid bit, tag, 256-bit line. No writes from fetch, no dirty state, no write-back.
- States: CHECK (reset state), FILL.
- CHECK, mem_read=1, hit (valid[index] and tag match): mem_resp=1, mem_rdata = line word [4:2]. Stay in CHECK.
- CHECK, mem_read=1, miss: mem_resp=0. Latch {tag, index} into fill_addr. Go to FILL.
- CHECK, mem_read=0: no outputs asserted, no state change.
- FILL: pmem_read=1, pmem_address={fill_addr, 5'b0}. These use the latched address, not live mem_address.
- FILL with pmem_resp=1: write pmem_rdata, set valid, write tag at the latched index. Go to CHECK. No mem_resp in this cycle.
- If mem_address changes or mem_read drops during FILL, the fill still completes for the latched line. The new address is evaluated in CHECK afterwards.

## Timing
- Reset values: state=CHECK, all valid=0, fill_addr=0. mem_resp=0, mem_rdata=0, pmem_read=0, pmem_address=0.
- Hit latency: 0 cycles. mem_resp is asserted in the same cycle as mem_read.
- Miss latency: the FILL state is entered at the edge after the miss. pmem_read is high from that cycle until the pmem_resp cycle inclusive. mem_resp follows one cycle after pmem_resp. Total = 2 + N cycles, where N is the number of pmem wait cycles.
- Back-to-back hits: one response per cycle.
- Reset during FILL: next state is CHECK and all valid bits clear. A pmem_resp in the reset cycle is discarded (reset wins). pmem_read is 0 in the following cycle.
- Reset with mem_read high: mem_resp=0 in the reset cycle (outputs gated by reset).
- mem_address bits [1:0] are non-zero: ignored, and the word is selected by [4:2].

## Structure
- Shared package rv32i_types: rv32i_word (existing). Add icache_state_t enum {CHECK, FILL} and icache_line_t (logic [255:0]).
- Sub-module icache_array, parameterised by NUM_SETS:
  - Holds the valid, tag and data arrays.
  - Synchronous write with synchronous valid clear on reset.
  - Asynchronous read by index.
- Top level holds the FSM, fill_addr register, hit compare and word mux.

## Test plan
- Cold miss: reset, then mem_read=1 at 0x0000_0044.
  - Expect pmem_read=1 with pmem_address=0x0000_0040 from the next cycle.
  - Return pmem_resp after 3 cycles with word k = 0xA000_0000+k.
  - One cycle later expect mem_resp=1, mem_rdata=0xA000_0001.
- Hit on the same line: then address 0x0000_005C → same-cycle mem_resp=1, mem_rdata=0xA000_0007, pmem_read=0.
- Conflict eviction (NUM_SETS=8):
  - Request 0x0000_0140 (same index 2, different tag) → miss, pmem_address=0x0000_0140; fill with 0xB000_000k.
  - 0x0000_0140 then hits with 0xB000_0000.
  - 0x0000_0040 misses again.
- Address change mid-fill: miss on 0x0000_0080, then drive address 0x0000_0100 during FILL.
  - pmem_address stays 0x0000_0080.
  - After the fill, a second miss fetches 0x0000_0100.
  - 0x0000_0080 later hits.
- Reset mid-fill: assert reset in the same cycle as pmem_resp.
  - Next cycle pmem_read=0, mem_resp=0.
  - The same address misses again afterwards.
- Idle: mem_read=0 for 10 cycles after reset → mem_resp=0, pmem_read=0 throughout.
